// File: rtl/axi_rd_responder_addr16_data8_id4.sv
// axi_rd_responder_addr16_data8_id4: AXI4 AR/R responder over a 64 KiB byte memory with preload port
module axi_rd_responder_addr16_data8_id4 #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [ID_W-1:0]   axi_arid,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [7:0]        axi_arlen,
  input  logic [1:0]        axi_arsize,
  input  logic [1:0]        axi_arburst,
  input  logic [1:0]        axi_arlock,
  input  logic [3:0]        axi_arcache,
  input  logic [2:0]        axi_arprot,
  input  logic [3:0]        axi_arqos,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [ID_W-1:0]   axi_rid,
  output logic [7:0]        axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rlast,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [7:0]        mem_wdata,
  output logic              busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);
  logic [1:0]        r_state;
  logic [7:0]        r_cnt;
  logic [7:0]        r_beat;
  logic [7:0]        r_len;
  logic [ADDR_W-1:0] r_addr;
  logic              r_fixed;
  logic              r_err;
  logic [7:0]        r_mem [0:(2**ADDR_W)-1];
  logic              w_hs;
  logic              w_acc;
  logic              w_load;
  logic              w_done;
  logic              w_unused;
  assign w_hs     = axi_arvalid & axi_arready;
  assign w_acc    = axi_rvalid & axi_rready;
  assign w_load   = (r_state == S_WAIT && r_cnt == 8'd0) || (r_state == S_BURST && w_acc && !axi_rlast);
  assign w_done   = r_state == S_BURST && w_acc && axi_rlast;
  assign busy     = r_state != S_IDLE;
  assign w_unused = ^{axi_arlock, axi_arcache, axi_arprot, axi_arqos};
  // Memory read happens with the old contents, so a same-edge preload is seen only by later beats
  always_ff @(posedge clk)
    if (mem_we) r_mem[mem_waddr] <= mem_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rresp   <= 2'd0;
      axi_rid     <= '0;
      axi_rdata   <= 8'd0;
      r_cnt       <= 8'd0;
      r_beat      <= 8'd0;
      r_len       <= 8'd0;
      r_addr      <= '0;
      r_fixed     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      axi_arready <= (r_state == S_IDLE && !w_hs) || w_done;
      if (w_hs) begin
        r_state <= S_WAIT;
        axi_rid <= axi_arid;
        r_addr  <= axi_araddr;
        r_len   <= axi_arlen;
        r_fixed <= axi_arburst == 2'd0;
        r_err   <= axi_arsize != 2'd0 || axi_arburst[1];
        r_beat  <= 8'd0;
        r_cnt   <= LAT_M1;
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_load) begin
        r_state    <= S_BURST;
        axi_rvalid <= 1'b1;
        axi_rdata  <= r_err ? 8'd0 : r_mem[r_addr];
        axi_rresp  <= r_err ? 2'd2 : 2'd0;
        axi_rlast  <= r_beat == r_len;
        r_beat     <= r_beat + 1'b1;
        r_addr     <= r_fixed ? r_addr : r_addr + 1'b1;
      end
      if (w_done) begin
        r_state    <= S_IDLE;
        axi_rvalid <= 1'b0;
        axi_rlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_responder_addr16_data8_id4.sv
// tb_axi_rd_responder_addr16_data8_id4: directed bursts checked against a queue-based beat model
module tb_axi_rd_responder_addr16_data8_id4;
  localparam int LATENCY = 2;
  logic clk = 0;
  logic reset = 1;
  logic axi_arvalid = 0, axi_arready;
  logic [3:0] axi_arid = 0;
  logic [15:0] axi_araddr = 0;
  logic [7:0] axi_arlen = 0;
  logic [1:0] axi_arsize = 0, axi_arburst = 0, axi_arlock = 0;
  logic [3:0] axi_arcache = 0, axi_arqos = 0;
  logic [2:0] axi_arprot = 0;
  logic axi_rvalid, axi_rready = 0, axi_rlast;
  logic [3:0] axi_rid;
  logic [7:0] axi_rdata;
  logic [1:0] axi_rresp;
  logic mem_we = 0;
  logic [15:0] mem_waddr = 0;
  logic [7:0] mem_wdata = 0;
  logic busy;
  typedef struct packed {logic [7:0] d; logic [3:0] id; logic [1:0] resp; logic last;} beat_t;
  beat_t exp_q[$];
  logic [7:0] lg[$];
  logic [7:0] mm [0:65535];
  int checks = 0, failures = 0, pops = 0;
  axi_rd_responder_addr16_data8_id4 #(.ID_W(4), .ADDR_W(16), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_arqos(axi_arqos), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  always @(negedge clk)
    if (!reset && axi_rvalid) begin
      if (exp_q.size() == 0) chk("spurious_beat", exp_q.size(), 1);
      else begin
        chk("rdata", axi_rdata, exp_q[0].d);
        chk("rid", axi_rid, exp_q[0].id);
        chk("rresp", axi_rresp, exp_q[0].resp);
        chk("rlast", axi_rlast, exp_q[0].last);
        chk("busy_in_burst", busy, 1);
      end
    end
  always @(posedge clk)
    if (!reset && axi_rvalid && axi_rready && exp_q.size() > 0) begin
      lg.push_back(axi_rdata);
      void'(exp_q.pop_front());
      pops++;
    end
  task automatic issue(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                       input logic [1:0] sz, input logic [1:0] bu);
    bit err;
    logic [15:0] ba;
    int j;
    err = sz != 0 || bu >= 2;
    exp_q.delete();
    lg.delete();
    pops = 0;
    for (int k = 0; k <= int'(len); k++) begin
      ba = (bu == 0) ? a : a + 16'(k);
      exp_q.push_back('{d: err ? 8'h00 : mm[ba], id: id, resp: err ? 2'd2 : 2'd0, last: k == int'(len)});
    end
    j = 0;
    while (!axi_arready && j < 50) begin
      @(negedge clk);
      j++;
    end
    chk("arready_wait", axi_arready, 1);
    axi_arvalid = 1; axi_arid = id; axi_araddr = a; axi_arlen = len; axi_arsize = sz; axi_arburst = bu;
    @(posedge clk);
    @(negedge clk);
    axi_arvalid = 0; axi_arid = 4'hF; axi_araddr = 16'hDEAD; axi_arlen = 8'hFF;
  endtask
  task automatic run(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                     input logic [1:0] sz, input logic [1:0] bu, input logic [3:0] pat,
                     input int we_idx, input logic [15:0] we_a, input logic [7:0] we_d);
    int i, first;
    issue(id, a, len, sz, bu);
    i = 0;
    first = -1;
    while (exp_q.size() > 0 && i < 300) begin
      if (axi_rvalid && first < 0) first = i;
      axi_rready = pat[i % 4];
      mem_we = i == we_idx; mem_waddr = we_a; mem_wdata = we_d;
      @(negedge clk);
      i++;
    end
    mem_we = 0;
    axi_rready = 0;
    if (we_idx >= 0) mm[we_a] = we_d;
    chk("burst_complete", exp_q.size(), 0);
    chk("first_beat_latency", first, LATENCY);
    chk("rvalid_after_last", axi_rvalid, 0);
    chk("arready_after_last", axi_arready, 1);
    chk("busy_after_last", busy, 0);
  endtask
  task automatic pin(input string nm, input int idx, input logic [7:0] v);
    chk(nm, lg.size() > idx ? int'(lg[idx]) : -1, v);
  endtask
  initial begin
    int i;
    @(negedge clk);
    chk("rst_arready", axi_arready, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_rid", axi_rid, 0);
    chk("rst_rresp", axi_rresp, 0);
    chk("rst_rlast", axi_rlast, 0);
    reset = 0;
    @(negedge clk);
    chk("arready_out_of_reset", axi_arready, 1);
    for (int a = 0; a < 96; a++) begin
      mem_we = 1;
      mem_waddr = a < 80 ? 16'(a) : 16'hFFF0 + 16'(a - 80);
      mem_wdata = mem_waddr[7:0] ^ 8'hA5;
      mm[mem_waddr] = mem_wdata;
      @(negedge clk);
    end
    mem_we = 0;
    run(4'd5, 16'h0010, 8'd3, 2'd0, 2'd1, 4'hF, -1, 16'h0, 8'h0);
    pin("incr_b0", 0, 8'hB5); pin("incr_b1", 1, 8'hB4); pin("incr_b2", 2, 8'hB7); pin("incr_b3", 3, 8'hB6);
    run(4'd2, 16'hFFFE, 8'd3, 2'd0, 2'd1, 4'hF, -1, 16'h0, 8'h0);
    pin("wrap_b0", 0, 8'h5B); pin("wrap_b1", 1, 8'h5A); pin("wrap_b2", 2, 8'hA5); pin("wrap_b3", 3, 8'hA4);
    run(4'd7, 16'h0040, 8'd2, 2'd0, 2'd0, 4'b0110, -1, 16'h0, 8'h0);
    pin("fixed_b0", 0, 8'hE5); pin("fixed_b2", 2, 8'hE5);
    run(4'd3, 16'h0011, 8'd1, 2'd1, 2'd1, 4'hF, -1, 16'h0, 8'h0);
    run(4'd4, 16'h0012, 8'd0, 2'd0, 2'd2, 4'hF, -1, 16'h0, 8'h0);
    pin("err_data", 0, 8'h00);
    issue(4'd9, 16'h0000, 8'd7, 2'd0, 2'd1);
    i = 0;
    while (pops < 2 && i < 50) begin
      axi_rready = 1;
      @(negedge clk);
      i++;
    end
    chk("two_beats_before_reset", pops, 2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    axi_rready = 0;
    exp_q.delete();
    chk("abort_rvalid", axi_rvalid, 0);
    chk("abort_arready", axi_arready, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_arready_back", axi_arready, 1);
    run(4'd1, 16'h0000, 8'd0, 2'd0, 2'd1, 4'hF, -1, 16'h0, 8'h0);
    pin("post_reset_b0", 0, 8'hA5);
    run(4'd6, 16'h0020, 8'd3, 2'd0, 2'd1, 4'hF, 2, 16'h0021, 8'h3C);
    pin("coll_b0", 0, 8'h85); pin("coll_b1_old", 1, 8'h84); pin("coll_b2", 2, 8'h87);
    run(4'd6, 16'h0020, 8'd3, 2'd0, 2'd1, 4'hF, -1, 16'h0, 8'h0);
    pin("coll_rep_b1_new", 1, 8'h3C); pin("coll_rep_b3", 3, 8'h86);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
